uart_ctrl: RTL and testbench

Parametrised buffered UART transceiver: the next-generation replacement for the board-level UART instanced under `mkTop`. Serialises bytes from a valid/ready input stream onto `tx` and deserialises `rx` into a valid/ready output stream, with TX and RX FIFOs and a configurable bit period. Sticky error flags and board LED status are included. It sits between the FTDI pins and the core's MMIO/stream fabric.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_fifo.sv | 47 ++++
 rtl/uart_ctrl.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, LED bit map and timing helper for the buffered UART.
// Optional even-parity support is selected with the UART_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    TxIdle,
    TxStart,
    TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_t;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop
  } rx_state_t;

  localparam int unsigned LedOutValid = 0;
  localparam int unsigned LedTxBusy   = 1;
  localparam int unsigned LedFrameErr = 2;
  localparam int unsigned LedOverrun  = 3;
  localparam int unsigned LedRxLo     = 4;

  // Mid-bit offset used by the receiver to centre on the start bit.
  function automatic int unsigned div_half(input int unsigned div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count; pointers carry an extra wrap bit so
// full and empty are distinguishable. Pushes when full and pops when empty are ignored.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           push,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rptr_q[AW-1:0]];
  assign count    = CW'(wptr_q - rptr_q);

endmodule

// File: rtl/uart_ctrl.sv
// Buffered UART transceiver: TX/RX FIFOs, bit-timed TX/RX FSMs, sticky errors, LED status.
// Define UART_PARITY_EN to add an even-parity bit to every frame.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DIV    = 217,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx,
  output logic                       tx,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       clear_err,
  output logic [$clog2(DEPTH+1)-1:0] tx_count,
  output logic [$clog2(DEPTH+1)-1:0] rx_count,
  output logic                       frame_err,
  output logic                       overrun,
  output logic [7:0]                 led
);

  localparam int unsigned TW = $clog2(DIV);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam logic [TW-1:0] TLast = TW'(DIV - 1);
  localparam logic [TW-1:0] THalf = TW'(div_half(DIV));
  localparam logic [BW-1:0] BLast = BW'(DATA_W - 1);

  logic              tx_full, tx_empty, tx_pop;
  logic [DATA_W-1:0] tx_head;
  logic              rx_full, rx_empty, rx_push;

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_data (in_data),
    .push      (in_valid),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  assign in_ready = !tx_full;

  // ---------------- TX ----------------
  tx_state_t         tx_state_q, tx_state_d;
  logic [TW-1:0]     tx_timer_q, tx_timer_d;
  logic [BW-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              tx_tick;
`ifdef UART_PARITY_EN
  logic              tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_timer_d = '0;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
`ifdef UART_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_tick = (tx_timer_q == TLast);
    if (tx_state_q != TxIdle && !tx_tick) tx_timer_d = tx_timer_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_state_d = TxStart;
        end
      end
      TxStart: begin
        if (tx_tick) begin
          tx_state_d = TxData;
          tx_bit_d   = '0;
        end
      end
      TxData: begin
        if (tx_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == BLast) begin
`ifdef UART_PARITY_EN
            tx_state_d = TxParity;
`else
            tx_state_d = TxStop;
`endif
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      TxParity: if (tx_tick) tx_state_d = TxStop;
`endif
      TxStop: begin
        // Back-to-back frames: chain straight into the next start bit.
        if (tx_tick) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_state_d = TxStart;
          end else begin
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
    if (tx_pop) begin
      tx_shift_d = tx_head;
`ifdef UART_PARITY_EN
      tx_par_d   = ^tx_head;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TxIdle;
      tx_timer_q <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_timer_q <= tx_timer_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
`ifdef UART_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state_q)
      TxStart:  tx = 1'b0;
      TxData:   tx = tx_shift_q[0];
`ifdef UART_PARITY_EN
      TxParity: tx = tx_par_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  logic [1:0]        rx_sync_q;
  logic              rx_s;
  rx_state_t         rx_state_q, rx_state_d;
  logic [TW-1:0]     rx_timer_q, rx_timer_d;
  logic [BW-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic              rx_tick, rx_par_ok, frame_set, overrun_set;
  logic              frame_err_q, overrun_q;
  logic [3:0]        led_nib_q;
`ifdef UART_PARITY_EN
  logic              rx_par_q, rx_par_d;
  assign rx_par_ok = (rx_par_q == ^rx_shift_q);
`else
  assign rx_par_ok = 1'b1;
`endif

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_timer_d  = (rx_state_q == RxIdle) ? '0 : rx_timer_q + 1'b1;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    frame_set   = 1'b0;
    overrun_set = 1'b0;
`ifdef UART_PARITY_EN
    rx_par_d    = rx_par_q;
`endif
    rx_tick = (rx_timer_q == TLast);
    unique case (rx_state_q)
      RxIdle: if (!rx_s) rx_state_d = RxStart;
      RxStart: begin
        if (rx_timer_q == THalf) begin
          rx_timer_d = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (rx_tick) begin
          rx_timer_d = '0;
          rx_shift_d = {rx_s, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_q == BLast) begin
`ifdef UART_PARITY_EN
            rx_state_d = RxParity;
`else
            rx_state_d = RxStop;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RxParity: begin
        if (rx_tick) begin
          rx_timer_d = '0;
          rx_par_d   = rx_s;
          rx_state_d = RxStop;
        end
      end
`endif
      RxStop: begin
        // Return to idle at the stop sample so the next start edge is caught early.
        if (rx_tick) begin
          rx_state_d = RxIdle;
          if (rx_s && rx_par_ok) begin
            if (rx_full) overrun_set = 1'b1;
            else         rx_push     = 1'b1;
          end else begin
            frame_set = 1'b1;
          end
        end
      end
      default: rx_state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync_q   <= 2'b11;
      rx_state_q  <= RxIdle;
      rx_timer_q  <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      led_nib_q   <= '0;
`ifdef UART_PARITY_EN
      rx_par_q    <= 1'b0;
`endif
    end else begin
      rx_sync_q  <= {rx_sync_q[0], rx};
      rx_state_q <= rx_state_d;
      rx_timer_q <= rx_timer_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
`ifdef UART_PARITY_EN
      rx_par_q   <= rx_par_d;
`endif
      if (frame_set)      frame_err_q <= 1'b1;
      else if (clear_err) frame_err_q <= 1'b0;
      if (overrun_set)    overrun_q   <= 1'b1;
      else if (clear_err) overrun_q   <= 1'b0;
      if (rx_push)        led_nib_q   <= rx_shift_q[3:0];
    end
  end

  uart_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push_data (rx_shift_q),
    .push      (rx_push),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign out_valid = !rx_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

  always_comb begin
    led                  = '0;
    led[LedOutValid]     = out_valid;
    led[LedTxBusy]       = (tx_state_q != TxIdle);
    led[LedFrameErr]     = frame_err_q;
    led[LedOverrun]      = overrun_q;
    led[LedRxLo +: 4]    = led_nib_q;
  end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed/randomised bench for uart_ctrl (DIV=8, DATA_W=8, DEPTH=4) with a
// frame-level reference model for the serial line and byte queues for the streams.
module tb_uart_ctrl;
  import uart_pkg::*;

  localparam int unsigned Div      = 8;
  localparam int unsigned DataW    = 8;
  localparam int unsigned Depth    = 4;
  localparam int unsigned Cw       = $clog2(Depth + 1);
  localparam int unsigned FrameLen = (DataW + 2) * Div;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx;
  logic          rx_drv = 1'b1;
  logic          loop = 1'b0;
  logic          tx;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          clear_err = 1'b0;
  logic [Cw-1:0] tx_count, rx_count;
  logic          frame_err, overrun;
  logic [7:0]    led;

  int vectors = 0;
  int fails   = 0;
  logic [7:0] tx_exp[$];

  assign rx = loop ? tx : rx_drv;
  always #5 clock = ~clock;

  uart_ctrl #(.DIV(Div), .DATA_W(DataW), .DEPTH(Depth)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .tx        (tx),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clear_err (clear_err),
    .tx_count  (tx_count),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .led       (led)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level of bit slot pos (0 = start, 1..DataW = data LSB first, then stop).
  function automatic logic frame_level(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos > int'(DataW)) return 1'b1;
    return b[pos-1];
  endfunction

  // Called at the negedge of stream sample index 'first'; walks every queued frame.
  task automatic check_tx_stream(input int first);
    for (int i = first; i < tx_exp.size() * int'(FrameLen); i++) begin
      check("tx_wave", 32'(tx), 32'(frame_level(tx_exp[i / FrameLen], (i % FrameLen) / Div)));
      check("tx_busy", 32'(led[LedTxBusy]), 32'd1);
      @(negedge clock);
    end
    check("tx_idle_level", 32'(tx), 32'd1);
    check("tx_idle_busy", 32'(led[LedTxBusy]), 32'd0);
  endtask

  // Returns at the negedge following the accepting clock edge.
  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop);
    for (int p = 0; p < int'(DataW) + 2; p++) begin
      rx_drv = (p == int'(DataW) + 1) ? stop : frame_level(b, p);
      repeat (Div) @(negedge clock);
    end
    rx_drv = 1'b1;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_tx_count"}, 32'(tx_count), 32'd0);
    check({tag, "_rx_count"}, 32'(rx_count), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
  endtask

  initial begin
    int         first, highs, t;
    logic [7:0] got, b;
    logic [7:0] sent[$];
    logic [7:0] rcvd[$];

    // Reset state
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check_idle_reset("reset");

    // TX single 0xA5: tx still high at N+1, falls at N+2
    tx_exp = {8'hA5};
    push_byte(8'hA5);
    check("tx_latency_pre", 32'(tx), 32'd1);
    @(negedge clock);
    check_tx_stream(0);

    // TX single, random byte
    b = 8'($urandom);
    tx_exp = {b};
    push_byte(b);
    @(negedge clock);
    check_tx_stream(0);

    // TX burst: contiguous frames, FIFO counts up then drains
    tx_exp = {8'h01, 8'h02, 8'h03};
    push_byte(8'h01);
    check("burst_count1", 32'(tx_count), 32'd1);
    push_byte(8'h02);
    push_byte(8'h03);
    check("burst_count_after", 32'(tx_count), 32'd2);
    check_tx_stream(1);
    check("burst_drained", 32'(tx_count), 32'd0);

    // RX loopback 0x3C with out_ready high
    loop      = 1'b1;
    out_ready = 1'b1;
    push_byte(8'h3C);
    first = -1;
    highs = 0;
    got   = '0;
    for (t = 0; t < 300; t++) begin
      if (out_valid) begin
        if (first < 0) begin
          first = t;
          got   = out_data;
        end
        highs++;
      end
      @(negedge clock);
    end
    // tx falls at t=1; stop sample 79 cycles later; out_valid one cycle after that
    check("rx_latency", 32'(first), 32'd81);
    check("rx_valid_cycles", 32'(highs), 32'd1);
    check("rx_data", 32'(got), 32'h3C);
    check("rx_led_nibble", 32'(led[7:4]), 32'hC);
    check("rx_led_valid", 32'(led[LedOutValid]), 32'd0);

    // Random loopback burst
    sent = {};
    rcvd = {};
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      sent.push_back(b);
      push_byte(b);
    end
    for (int c = 0; c < 400; c++) begin
      if (out_valid) rcvd.push_back(out_data);
      @(negedge clock);
    end
    check("loop_rcvd_n", 32'(rcvd.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      check("loop_byte", 32'(rcvd.size() > k ? rcvd[k] : 8'hxx), 32'(sent[k]));
    check("loop_led_nibble", 32'(led[7:4]), 32'(sent[2][3:0]));

    // Overrun: Depth+1 bytes with consumer stalled
    out_ready = 1'b0;
    sent = {};
    for (int k = 0; k < int'(Depth) + 1; k++) begin
      b = 8'($urandom);
      sent.push_back(b);
      push_byte(b);
    end
    repeat ((Depth + 1) * FrameLen + 100) @(negedge clock);
    check("ovr_rx_count", 32'(rx_count), 32'(Depth));
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_led", 32'(led[LedOverrun]), 32'd1);
    check("ovr_no_frame_err", 32'(frame_err), 32'd0);
    for (int k = 0; k < int'(Depth); k++) begin
      check("ovr_valid", 32'(out_valid), 32'd1);
      check("ovr_byte", 32'(out_data), 32'(sent[k]));
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
    end
    check("ovr_drained", 32'(out_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    check("ovr_cleared", 32'(overrun), 32'd0);

    // Framing error: stop bit low discards the byte
    loop = 1'b0;
    drive_frame(8'h5A, 1'b0);
    repeat (40) @(negedge clock);
    check("fe_rx_count", 32'(rx_count), 32'd0);
    check("fe_flag", 32'(frame_err), 32'd1);
    check("fe_led", 32'(led[LedFrameErr]), 32'd1);

    // A good hand-driven frame still gets through; flag stays sticky
    b = 8'($urandom);
    drive_frame(b, 1'b1);
    repeat (20) @(negedge clock);
    check("man_valid", 32'(out_valid), 32'd1);
    check("man_data", 32'(out_data), 32'(b));
    check("man_led_nibble", 32'(led[7:4]), 32'(b[3:0]));
    check("fe_sticky", 32'(frame_err), 32'd1);
    out_ready = 1'b1;
    clear_err = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    clear_err = 1'b0;
    check("fe_cleared", 32'(frame_err), 32'd0);

    // Two-cycle low glitch: rejected at the start-bit resample
    rx_drv = 1'b0;
    repeat (2) @(negedge clock);
    rx_drv = 1'b1;
    repeat (30) @(negedge clock);
    check("glitch_rx_count", 32'(rx_count), 32'd0);
    check("glitch_no_err", 32'(frame_err), 32'd0);

    // Reset during the 4th data bit of a TX frame
    push_byte(8'hC3);
    push_byte(8'h99);
    repeat (34) @(negedge clock);
    check("mid_tx_count", 32'(tx_count), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle_reset("mid_reset");
    reset = 1'b0;
    b = 8'($urandom);
    tx_exp = {b};
    push_byte(b);
    @(negedge clock);
    check_tx_stream(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
